// File: rtl/vending_change_controller_if.sv
// Front-panel / dispenser signal bundle for vending_change_controller.
//
// Handshake semantics: this bundle has no valid/ready pair and no
// backpressure. Every input is sampled on each rising clock edge.
// i_input_coin and i_trigger_return are one-cycle events. i_select_item
// is a level that is evaluated each cycle. o_output_item, o_return_coin
// and o_coin_reject are single-cycle registered pulses. The dispensers
// must accept a pulse in the cycle in which it is shown.
//
// Signals:
//   i_input_coin      one-hot coin inserted this cycle (multi-hot is rejected)
//   i_select_item     item select request, level per cycle
//   i_trigger_return  user return request, one-cycle pulse
//   o_available_item  item i is affordable and a purchase is possible
//   o_output_item     one-hot dispense pulse
//   o_return_coin     one-hot coin-return pulse
//   o_current_total   registered credit
//   o_wait_time       registered inactivity timer
//   o_busy            change return in progress
//   o_coin_reject     pulse: coin not accepted
//   o_state           FSM state, for debug and checker binding
interface vending_change_controller_if #(
  parameter int kNumCoins  = 3,
  parameter int kNumItems  = 4,
  parameter int kTotalBits = 31
);
  logic [kNumCoins-1:0]  i_input_coin;
  logic [kNumItems-1:0]  i_select_item;
  logic                  i_trigger_return;
  logic [kNumItems-1:0]  o_available_item;
  logic [kNumItems-1:0]  o_output_item;
  logic [kNumCoins-1:0]  o_return_coin;
  logic [kTotalBits-1:0] o_current_total;
  logic [31:0]           o_wait_time;
  logic                  o_busy;
  logic                  o_coin_reject;
  logic [1:0]            o_state;

  modport slave (
    input  i_input_coin, i_select_item, i_trigger_return,
    output o_available_item, o_output_item, o_return_coin,
    output o_current_total, o_wait_time, o_busy, o_coin_reject, o_state
  );

  modport master (
    output i_input_coin, i_select_item, i_trigger_return,
    input  o_available_item, o_output_item, o_return_coin,
    input  o_current_total, o_wait_time, o_busy, o_coin_reject, o_state
  );
endinterface

// File: rtl/vending_change_controller.sv
// vending_change_controller: this module owns the credit total and the
// inactivity timer of the vending machine. It accepts coins and item
// selections. When a return is triggered or the timer expires, it pays
// out change one coin per cycle using a greedy largest-first rule.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      vending_change_controller_if.slave (see the interface file)
//
// FSM states: IDLE (no credit), ACCUM (credit held, timer running),
// RETURN (paying out change). o_state exposes the current state.
module vending_change_controller #(
  parameter int          kNumCoins  = 3,
  parameter int          kNumItems  = 4,
  parameter int          kTotalBits = 31,
  parameter int          kWaitTime  = 10,
  parameter int unsigned COIN0      = 100,
  parameter int unsigned COIN1      = 500,
  parameter int unsigned COIN2      = 1000,
  parameter int unsigned PRICE0     = 400,
  parameter int unsigned PRICE1     = 500,
  parameter int unsigned PRICE2     = 1000,
  parameter int unsigned PRICE3     = 2000
) (
  input logic                        clk,
  input logic                        reset_n,
  vending_change_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

  localparam logic [kTotalBits-1:0] kCoin0 = kTotalBits'(COIN0);
  localparam logic [kTotalBits-1:0] kCoin1 = kTotalBits'(COIN1);
  localparam logic [kTotalBits-1:0] kCoin2 = kTotalBits'(COIN2);
  localparam logic [kTotalBits-1:0] kPrice [kNumItems] = '{
    kTotalBits'(PRICE0), kTotalBits'(PRICE1),
    kTotalBits'(PRICE2), kTotalBits'(PRICE3)
  };
  localparam logic [31:0] kReload = 32'(kWaitTime);

  state_t                state_q, state_d;
  logic [kTotalBits-1:0] total_q, total_d;
  logic [31:0]           timer_q, timer_d;
  logic [kNumItems-1:0]  output_item_q, output_item_d;
  logic [kNumCoins-1:0]  return_coin_q, return_coin_d;
  logic                  coin_reject_q, coin_reject_d;

  // Coin decode. Only a clean one-hot pattern has a value. A multi-hot
  // pattern counts as present but illegal, so it is rejected.
  logic                  coin_present;
  logic                  coin_legal;
  logic [kTotalBits-1:0] coin_value;
  logic [kTotalBits:0]   coin_sum;
  logic                  coin_ok;

  always_comb begin
    coin_present = |bus.i_input_coin;
    coin_legal   = 1'b0;
    coin_value   = '0;
    if (bus.i_input_coin == 3'b001) begin
      coin_legal = 1'b1;
      coin_value = kCoin0;
    end else if (bus.i_input_coin == 3'b010) begin
      coin_legal = 1'b1;
      coin_value = kCoin1;
    end else if (bus.i_input_coin == 3'b100) begin
      coin_legal = 1'b1;
      coin_value = kCoin2;
    end
  end

  // The extra carry bit detects credit overflow before the coin is taken.
  assign coin_sum = {1'b0, total_q} + {1'b0, coin_value};
  assign coin_ok  = coin_legal & ~coin_sum[kTotalBits];

  // Selection uses the pre-coin total, so a coin that arrives in the same
  // cycle cannot make an item affordable. The descending scan lets the
  // lowest affordable index win.
  logic                  sel_hit;
  logic [kTotalBits-1:0] sel_price;
  logic [kNumItems-1:0]  sel_onehot;

  always_comb begin
    sel_hit    = 1'b0;
    sel_price  = '0;
    sel_onehot = '0;
    for (int i = kNumItems - 1; i >= 0; i--) begin
      if (bus.i_select_item[i] && (kPrice[i] <= total_q)) begin
        sel_hit       = 1'b1;
        sel_price     = kPrice[i];
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Greedy change: pick the largest coin that still fits in the credit.
  logic                  pick_hit;
  logic [kTotalBits-1:0] pick_value;
  logic [kNumCoins-1:0]  pick_onehot;
  logic [kTotalBits-1:0] pick_rest;

  always_comb begin
    pick_hit    = 1'b1;
    pick_value  = '0;
    pick_onehot = '0;
    if (total_q >= kCoin2) begin
      pick_value  = kCoin2;
      pick_onehot = 3'b100;
    end else if (total_q >= kCoin1) begin
      pick_value  = kCoin1;
      pick_onehot = 3'b010;
    end else if (total_q >= kCoin0) begin
      pick_value  = kCoin0;
      pick_onehot = 3'b001;
    end else begin
      pick_hit = 1'b0;
    end
    pick_rest = total_q - pick_value;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    total_d       = total_q;
    timer_d       = timer_q;
    output_item_d = '0;
    return_coin_d = '0;
    coin_reject_d = coin_present & ~coin_ok;

    unique case (state_q)
      ST_IDLE: begin
        if (coin_ok) begin
          total_d = coin_sum[kTotalBits-1:0];
          timer_d = kReload;
          state_d = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (bus.i_trigger_return) begin
          // A trigger takes priority: any coin in this cycle is refused
          // and any select is dropped.
          coin_reject_d = coin_present;
          timer_d       = '0;
          if (total_q < kCoin0) begin
            total_d = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RETURN;
          end
        end else begin
          total_d = total_q
                  + (coin_ok ? coin_value : '0)
                  - (sel_hit ? sel_price : '0);
          output_item_d = sel_onehot;
          if (coin_ok || sel_hit) begin
            timer_d = kReload;
          end else if (timer_q == 32'd0) begin
            // The timer reached zero on the previous edge: pay out now.
            if (total_q < kCoin0) begin
              total_d = '0;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RETURN;
            end
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
      end

      ST_RETURN: begin
        coin_reject_d = coin_present;
        timer_d       = '0;
        if (pick_hit) begin
          return_coin_d = pick_onehot;
          total_d       = pick_rest;
          // Leave on the edge that pays out the last coin, so that o_busy
          // covers exactly the payout cycles.
          if (pick_rest < kCoin0) begin
            total_d = '0;
            state_d = ST_IDLE;
          end
        end else begin
          total_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        total_d = '0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      total_q       <= '0;
      timer_q       <= '0;
      output_item_q <= '0;
      return_coin_q <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      total_q       <= total_d;
      timer_q       <= timer_d;
      output_item_q <= output_item_d;
      return_coin_q <= return_coin_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  // Availability is combinational from registered state. It is zero while
  // change is being paid out.
  always_comb begin
    bus.o_available_item = '0;
    for (int i = 0; i < kNumItems; i++) begin
      bus.o_available_item[i] = (state_q != ST_RETURN) && (kPrice[i] <= total_q);
    end
  end

  assign bus.o_output_item   = output_item_q;
  assign bus.o_return_coin   = return_coin_q;
  assign bus.o_current_total = total_q;
  assign bus.o_wait_time     = timer_q;
  assign bus.o_busy          = (state_q == ST_RETURN);
  assign bus.o_coin_reject   = coin_reject_q;
  assign bus.o_state         = state_q;

endmodule

// File: tb/tb_vending_change_controller.sv
// Directed testbench for vending_change_controller. Inputs are driven 1 ns
// after the rising edge, and outputs are sampled at the same point, away
// from the active edge.
module tb_vending_change_controller;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  logic [2:0] exp_q[$];

  vending_change_controller_if bus ();

  vending_change_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] coin, input logic [3:0] sel, input logic trig);
    bus.i_input_coin     = coin;
    bus.i_select_item    = sel;
    bus.i_trigger_return = trig;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop the next expected returned coin and compare it.
  task automatic chk_coin(input string tag);
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(bus.o_return_coin), 32'(e));
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_total"}, 32'(bus.o_current_total), 32'd0);
    chk({tag, "_wait"}, bus.o_wait_time, 32'd0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    chk({tag, "_item"}, 32'(bus.o_output_item), 32'd0);
    chk({tag, "_ret"}, 32'(bus.o_return_coin), 32'd0);
    chk({tag, "_rej"}, 32'(bus.o_coin_reject), 32'd0);
    chk({tag, "_avail"}, 32'(bus.o_available_item), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    drive(3'b000, 4'b0000, 1'b0);

    // Reset.
    repeat (3) tick();
    chk_idle("in_reset");
    reset_n = 1'b1;
    tick();
    chk_idle("after_reset");

    // Insert 1000, then return it.
    drive(3'b100, 4'b0000, 1'b0); tick();
    drive(3'b000, 4'b0000, 1'b0);
    chk("c1000_total", 32'(bus.o_current_total), 32'd1000);
    chk("c1000_wait", bus.o_wait_time, 32'd10);
    chk("c1000_avail", 32'(bus.o_available_item), 32'b0111);
    drive(3'b000, 4'b0000, 1'b1); tick();
    drive(3'b000, 4'b0000, 1'b0);
    chk("ret1000_busy", 32'(bus.o_busy), 32'd1);
    chk("ret1000_avail", 32'(bus.o_available_item), 32'd0);
    exp_q.push_back(3'b100);
    tick();
    chk_coin("ret1000_coin");
    chk("ret1000_done_busy", 32'(bus.o_busy), 32'd0);
    chk("ret1000_done_total", 32'(bus.o_current_total), 32'd0);
    tick();
    chk("ret1000_pulse_end", 32'(bus.o_return_coin), 32'd0);

    // Purchase: 500 + 500, then select item0.
    drive(3'b010, 4'b0000, 1'b0); tick();
    chk("p500_rej", 32'(bus.o_coin_reject), 32'd0);
    tick();
    drive(3'b000, 4'b0001, 1'b0);
    chk("p1000_total", 32'(bus.o_current_total), 32'd1000);
    tick();
    drive(3'b000, 4'b1000, 1'b0);
    chk("buy0_item", 32'(bus.o_output_item), 32'b0001);
    chk("buy0_total", 32'(bus.o_current_total), 32'd600);
    chk("buy0_wait", bus.o_wait_time, 32'd10);
    tick();
    drive(3'b000, 4'b0000, 1'b0);
    chk("buy3_item", 32'(bus.o_output_item), 32'd0);
    chk("buy3_total", 32'(bus.o_current_total), 32'd600);
    chk("buy3_wait", bus.o_wait_time, 32'd9);

    // Coin 100 + select item1 at total 600: 600 + 100 - 500 = 200.
    drive(3'b001, 4'b0010, 1'b0); tick();
    chk("cs600_item", 32'(bus.o_output_item), 32'b0010);
    chk("cs600_total", 32'(bus.o_current_total), 32'd200);
    drive(3'b001, 4'b0000, 1'b0); tick(); tick();
    chk("to400_total", 32'(bus.o_current_total), 32'd400);
    // At 400 the pre-coin total cannot buy item1.
    drive(3'b001, 4'b0010, 1'b0); tick();
    chk("cs400_item", 32'(bus.o_output_item), 32'd0);
    chk("cs400_total", 32'(bus.o_current_total), 32'd500);
    // At 500 it can: 500 + 100 - 500 = 100.
    tick();
    chk("cs500_item", 32'(bus.o_output_item), 32'b0010);
    chk("cs500_total", 32'(bus.o_current_total), 32'd100);

    // Build 1700, then coin + trigger in the same cycle.
    drive(3'b100, 4'b0000, 1'b0); tick();
    drive(3'b010, 4'b0000, 1'b0); tick();
    drive(3'b001, 4'b0000, 1'b0); tick();
    chk("t1700_total", 32'(bus.o_current_total), 32'd1700);
    chk("t1700_avail", 32'(bus.o_available_item), 32'b0111);
    drive(3'b001, 4'b0000, 1'b1); tick();
    chk("trig_rej", 32'(bus.o_coin_reject), 32'd1);
    chk("trig_busy", 32'(bus.o_busy), 32'd1);
    chk("trig_total", 32'(bus.o_current_total), 32'd1700);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b001);
    // Coin during RETURN is rejected and does not disturb the change.
    drive(3'b010, 4'b0000, 1'b0); tick();
    drive(3'b000, 4'b0000, 1'b0);
    chk_coin("chg0");
    chk("chg0_rej", 32'(bus.o_coin_reject), 32'd1);
    chk("chg0_total", 32'(bus.o_current_total), 32'd700);
    chk("chg0_busy", 32'(bus.o_busy), 32'd1);
    tick();
    chk_coin("chg1");
    chk("chg1_total", 32'(bus.o_current_total), 32'd200);
    tick();
    chk_coin("chg2");
    chk("chg2_busy", 32'(bus.o_busy), 32'd1);
    tick();
    chk_coin("chg3");
    chk("chg3_busy", 32'(bus.o_busy), 32'd0);
    chk("chg3_total", 32'(bus.o_current_total), 32'd0);
    chk("chg_queue_left", 32'(exp_q.size()), 32'd0);
    tick();
    chk_idle("chg_end");

    // Timeout with 500 credit.
    drive(3'b010, 4'b0000, 1'b0); tick();
    drive(3'b000, 4'b0000, 1'b0);
    chk("to_wait_load", bus.o_wait_time, 32'd10);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("to_wait_%0d", i), bus.o_wait_time, 32'(10 - i));
    end
    chk("to_still_accum", 32'(bus.o_busy), 32'd0);
    chk("to_avail", 32'(bus.o_available_item), 32'b0011);
    tick();
    chk("to_busy", 32'(bus.o_busy), 32'd1);
    exp_q.push_back(3'b010);
    tick();
    chk_coin("to_coin");
    chk("to_done_busy", 32'(bus.o_busy), 32'd0);
    chk("to_done_total", 32'(bus.o_current_total), 32'd0);
    tick();

    // Multi-hot coin is rejected.
    drive(3'b011, 4'b0000, 1'b0); tick();
    drive(3'b000, 4'b0000, 1'b0);
    chk("mh_rej", 32'(bus.o_coin_reject), 32'd1);
    chk("mh_total", 32'(bus.o_current_total), 32'd0);
    chk("mh_busy", 32'(bus.o_busy), 32'd0);
    tick();
    chk("mh_rej_end", 32'(bus.o_coin_reject), 32'd0);

    // Exact-price buy, then trigger with zero credit: no payout.
    drive(3'b010, 4'b0000, 1'b0); tick();
    drive(3'b000, 4'b0010, 1'b0); tick();
    drive(3'b000, 4'b0000, 1'b1);
    chk("exact_item", 32'(bus.o_output_item), 32'b0010);
    chk("exact_total", 32'(bus.o_current_total), 32'd0);
    tick();
    drive(3'b000, 4'b0000, 1'b0);
    chk("zero_ret_busy", 32'(bus.o_busy), 32'd0);
    chk("zero_ret_coin", 32'(bus.o_return_coin), 32'd0);
    tick();
    chk("zero_ret_coin2", 32'(bus.o_return_coin), 32'd0);
    chk("zero_ret_avail", 32'(bus.o_available_item), 32'd0);

    // Async reset in the middle of RETURN at 1100.
    drive(3'b100, 4'b0000, 1'b0); tick();
    drive(3'b001, 4'b0000, 1'b0); tick();
    drive(3'b000, 4'b0000, 1'b1); tick();
    drive(3'b000, 4'b0000, 1'b0);
    chk("rst_pre_busy", 32'(bus.o_busy), 32'd1);
    chk("rst_pre_total", 32'(bus.o_current_total), 32'd1100);
    reset_n = 1'b0;
    #1;
    chk_idle("rst_mid");
    #1;
    reset_n = 1'b1;
    tick();
    chk_idle("rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
